// File: rtl/fpga_ram_nrmw_lvt.sv
`default_nettype none
// ============================================================================
// Module   : fpga_ram_nrmw_lvt
// Brief    : Multi-read / multi-write distributed RAM built from 1W1R banks
//            steered by a live-value table. Optional same-cycle write-to-read
//            forwarding is enabled by defining FPGA_RAM_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module fpga_ram_nrmw_lvt #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int READ_PORTS  = 6,
    parameter int WRITE_PORTS = 2,
    parameter int AW          = $clog2(DEPTH),
    parameter int LW          = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [READ_PORTS-1:0][AW-1:0]       raddr,
    output logic [READ_PORTS-1:0][WIDTH-1:0]    rdata,
    input  logic [WRITE_PORTS-1:0]              we,
    input  logic [WRITE_PORTS-1:0][AW-1:0]      waddr,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]   wdata,
    output logic                                wconf
);

    logic [LW-1:0]    lvt [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] bank_rd [WRITE_PORTS][READ_PORTS];
    logic             conflict;

    // One private copy of each write port's data per read port, so every
    // bank needs only a single async read port.
    genvar gw, gr;
    generate
        for (gw = 0; gw < WRITE_PORTS; gw++) begin : g_wr
            for (gr = 0; gr < READ_PORTS; gr++) begin : g_rd
                logic [WIDTH-1:0] mem [DEPTH];

                always_ff @(posedge clk) begin
                    if (rst_n && we[gw]) begin
                        mem[waddr[gw]] <= wdata[gw];
                    end
                end

                assign bank_rd[gw][gr] = mem[raddr[gr]];
            end
        end
    endgenerate

    // Later loop iterations override earlier ones, so the highest port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvt[i] <= '0;
            end
            valid <= '0;
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (we[w]) begin
                    lvt[waddr[w]]   <= LW'(w);
                    valid[waddr[w]] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            for (int j = i + 1; j < WRITE_PORTS; j++) begin
                if (we[i] && we[j] && (waddr[i] == waddr[j])) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wconf <= 1'b0;
        end else begin
            wconf <= conflict;
        end
    end

    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            rdata[r] = '0;
            if (valid[raddr[r]]) begin
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (lvt[raddr[r]] == LW'(w)) begin
                        rdata[r] = bank_rd[w][r];
                    end
                end
            end
`ifdef FPGA_RAM_BYPASS_EN
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (rst_n && we[w] && (waddr[w] == raddr[r])) begin
                    rdata[r] = wdata[w];
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire
